pipelined_divider_hs: RTL and testbench

//  Fully pipelined N-by-M integer divider with valid/ready handshake, backpressure, per-op signed/unsigned

---
 rtl/pipelined_divider_hs.sv | 182 ++++++++++++++++++
 tb/tb_pipelined_divider_hs.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_divider_hs.sv
// Pipelined restoring integer divider with valid/ready flow control, signed/unsigned mode,
// divide-by-zero / signed-overflow flags and a pass-through tag. One op issues per cycle.
module pipelined_divider_hs #(
    parameter int DIVIDENDLEN    = 16,
    parameter int DIVISORLEN     = 8,
    parameter int BITS_PER_STAGE = 1,
    parameter int TAGLEN         = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_signed,
    input  logic [DIVIDENDLEN-1:0] dividend,
    input  logic [DIVISORLEN-1:0]  divisor,
    input  logic [TAGLEN-1:0]      in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DIVIDENDLEN-1:0] quotient,
    output logic [DIVISORLEN-1:0]  remainder,
    output logic                   div_by_zero,
    output logic                   overflow,
    output logic [TAGLEN-1:0]      out_tag
);

    localparam int NSTAGE      = DIVIDENDLEN / BITS_PER_STAGE;
    localparam int DATAPATHLEN = DIVIDENDLEN + DIVISORLEN - 1;

    generate
        if (DIVIDENDLEN % BITS_PER_STAGE != 0) begin : g_bad_cfg
            $error("BITS_PER_STAGE must divide DIVIDENDLEN");
        end
    endgenerate

    // Operands travel as magnitudes; qneg/rneg carry the sign fix-up to the output register.
    typedef struct packed {
        logic                   valid;
        logic                   qneg;
        logic                   rneg;
        logic                   dbz;
        logic                   ovf;
        logic [TAGLEN-1:0]      tag;
        logic [DIVISORLEN-1:0]  dvs;
        logic [DATAPATHLEN-1:0] pr;
        logic [DIVIDENDLEN-1:0] q;
    } stage_t;

    typedef struct packed {
        logic [DIVIDENDLEN-1:0] q;
        logic [DIVISORLEN-1:0]  r;
        logic                   dbz;
        logic                   ovf;
        logic [TAGLEN-1:0]      tag;
    } result_t;

    // One group of BITS_PER_STAGE restoring iterations, quotient bits resolved MSB first.
    function automatic stage_t step(input stage_t s, input int group);
        stage_t               r;
        logic [DATAPATHLEN:0] dvs_ext;
        logic [DATAPATHLEN:0] trial;
        int                   k;
        r = s;
        for (int b = 0; b < BITS_PER_STAGE; b++) begin
            k       = DIVIDENDLEN - 1 - group * BITS_PER_STAGE - b;
            dvs_ext = '0;
            dvs_ext[DIVISORLEN-1:0] = r.dvs;
            trial   = {1'b0, r.pr} - (dvs_ext << k);
            if (!trial[DATAPATHLEN]) begin
                r.pr   = trial[DATAPATHLEN-1:0];
                r.q[k] = 1'b1;
            end
        end
        return r;
    endfunction

    // Last iteration group plus sign correction (truncate toward zero) and special cases.
    function automatic result_t retire(input stage_t s);
        stage_t  t;
        result_t o;
        t     = step(s, NSTAGE - 1);
        o.q   = t.qneg ? -t.q : t.q;
        // A zero divisor never subtracts, so pr still holds |dividend| and the sign fix restores
        // the raw low dividend bits in both modes.
        o.r   = t.rneg ? -t.pr[DIVISORLEN-1:0] : t.pr[DIVISORLEN-1:0];
        o.dbz = t.dbz;
        o.ovf = t.ovf;
        o.tag = t.tag;
        if (t.dbz) begin
            o.q = '1;
        end else if (t.ovf) begin
            o.q = '0;
            o.q[DIVIDENDLEN-1] = 1'b1;
            o.r = '0;
        end
        return o;
    endfunction

    logic                   adv;
    logic                   accept;
    logic [DIVIDENDLEN-1:0] dividend_abs;
    logic [DIVISORLEN-1:0]  divisor_abs;
    logic [DIVIDENDLEN-1:0] most_negative;
    stage_t                 load;
    stage_t                 pipe [NSTAGE];
    result_t                res;

    // Global stall: nothing moves unless the output register can hand its result over.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    assign accept   = in_valid && adv;

    // NOTE: every variable gets a default at the top of always_comb so no path infers a latch.
    always_comb begin
        most_negative = '0;
        most_negative[DIVIDENDLEN-1] = 1'b1;
        dividend_abs  = (in_signed && dividend[DIVIDENDLEN-1]) ? -dividend : dividend;
        divisor_abs   = (in_signed && divisor[DIVISORLEN-1])   ? -divisor  : divisor;
        load       = '0;
        load.valid = 1'b1;
        load.qneg  = in_signed && (dividend[DIVIDENDLEN-1] ^ divisor[DIVISORLEN-1]);
        load.rneg  = in_signed && dividend[DIVIDENDLEN-1];
        load.dbz   = (divisor == '0);
        load.ovf   = in_signed && (dividend == most_negative) && (divisor == '1);
        load.tag   = in_tag;
        load.dvs   = divisor_abs;
        load.pr    = DATAPATHLEN'(dividend_abs);
    end

    always_comb res = retire(pipe[NSTAGE-1]);

    // NOTE: the stage registers are plain flops, not a RAM, so they are all cleared on reset;
    // bubbles are loaded as all-zero so the sideband never carries stale data.
    always_ff @(posedge clock) begin
        if (reset) begin
            pipe[0] <= '0;
        end else if (adv) begin
            // NOTE: state updates use non-blocking assignment so every stage samples the
            // pre-edge value of its predecessor.
            pipe[0] <= accept ? load : '0;
        end
    end

    generate
        for (genvar j = 1; j < NSTAGE; j++) begin : g_stage
            always_ff @(posedge clock) begin
                if (reset) begin
                    pipe[j] <= '0;
                end else if (adv) begin
                    pipe[j] <= pipe[j-1].valid ? step(pipe[j-1], j - 1) : '0;
                end
            end
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid   <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            out_tag     <= '0;
        end else if (adv) begin
            if (pipe[NSTAGE-1].valid) begin
                out_valid   <= 1'b1;
                quotient    <= res.q;
                remainder   <= res.r;
                div_by_zero <= res.dbz;
                overflow    <= res.ovf;
                out_tag     <= res.tag;
            end else begin
                out_valid   <= 1'b0;
                quotient    <= '0;
                remainder   <= '0;
                div_by_zero <= 1'b0;
                overflow    <= 1'b0;
                out_tag     <= '0;
            end
        end
    end

endmodule

// File: tb/tb_pipelined_divider_hs.sv
// Directed bench for pipelined_divider_hs: latency, signed/unsigned values, flags, streaming
// under backpressure, mid-flight reset, and a radix-16 (4 bits/stage) instance.
module tb_pipelined_divider_hs;

    typedef struct packed {
        logic [15:0] q;
        logic [7:0]  r;
        logic        dz;
        logic        ov;
        logic [3:0]  tag;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid, in_valid4;
    logic        in_ready, in_ready4;
    logic        in_signed;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic [3:0]  in_tag;
    logic        out_ready;
    logic        out_valid, out_valid4;
    logic [15:0] quotient, quotient4;
    logic [7:0]  remainder, remainder4;
    logic        div_by_zero, div_by_zero4;
    logic        overflow, overflow4;
    logic [3:0]  out_tag, out_tag4;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [3:0]  tag_ctr = 4'd0;
    exp_t        expq[$];

    pipelined_divider_hs u_dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_signed(in_signed),
        .dividend(dividend), .divisor(divisor), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero), .overflow(overflow), .out_tag(out_tag)
    );

    pipelined_divider_hs #(.BITS_PER_STAGE(4)) u_dut4 (
        .clock(clock), .reset(reset),
        .in_valid(in_valid4), .in_ready(in_ready4), .in_signed(in_signed),
        .dividend(dividend), .divisor(divisor), .in_tag(in_tag),
        .out_valid(out_valid4), .out_ready(out_ready),
        .quotient(quotient4), .remainder(remainder4),
        .div_by_zero(div_by_zero4), .overflow(overflow4), .out_tag(out_tag4)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: SV native division (truncates toward zero) with the flag cases special-cased.
    function automatic exp_t model(input logic s, input logic [15:0] a, input logic [7:0] b,
                                   input logic [3:0] t);
        exp_t e;
        int   sa, sb;
        e.tag = t;
        e.dz  = 1'b0;
        e.ov  = 1'b0;
        if (b == 8'h00) begin
            e.q  = 16'hFFFF;
            e.r  = a[7:0];
            e.dz = 1'b1;
        end else if (s && a == 16'h8000 && b == 8'hFF) begin
            e.q  = 16'h8000;
            e.r  = 8'h00;
            e.ov = 1'b1;
        end else if (s) begin
            sa  = 32'($signed(a));
            sb  = 32'($signed(b));
            e.q = 16'(sa / sb);
            e.r = 8'(sa % sb);
        end else begin
            e.q = a / 16'(b);
            e.r = 8'(a % 16'(b));
        end
        return e;
    endfunction

    // Issue one op on the main instance (out_ready=1) and check the result it returns.
    task automatic run_op(input string tag, input logic s, input logic [15:0] a,
                          input logic [7:0] b, input logic [15:0] eq, input logic [7:0] er,
                          input logic edz, input logic eov);
        int         n;
        logic [3:0] t;
        n         = 0;
        t         = tag_ctr;
        tag_ctr   = tag_ctr + 4'd1;
        in_valid  = 1'b1;
        in_signed = s;
        dividend  = a;
        divisor   = b;
        in_tag    = t;
        @(negedge clock);
        in_valid = 1'b0;
        while (!out_valid && n < 40) begin
            @(negedge clock);
            n++;
        end
        check({tag, "_valid"}, 32'(out_valid), 1);
        check({tag, "_q"},     32'(quotient), 32'(eq));
        check({tag, "_r"},     32'(remainder), 32'(er));
        check({tag, "_dbz"},   32'(div_by_zero), 32'(edz));
        check({tag, "_ovf"},   32'(overflow), 32'(eov));
        check({tag, "_tag"},   32'(out_tag), 32'(t));
        @(negedge clock);
    endtask

    initial begin
        int         sent, got, cyc, stale, n;
        logic       acc, hold_chk;
        logic [31:0] snap;
        exp_t       e;

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_valid4 = 1'b0;
        in_signed = 1'b0;
        dividend  = '0;
        divisor   = '0;
        in_tag    = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clock);

        // Reset state
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_quotient",  32'(quotient), 0);
        check("rst_remainder", 32'(remainder), 0);
        check("rst_flags",     32'({div_by_zero, overflow}), 0);
        check("rst_out_tag",   32'(out_tag), 0);
        check("rst_out_valid4", 32'(out_valid4), 0);
        reset = 1'b0;
        #1;
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_in_ready4", 32'(in_ready4), 1);
        @(negedge clock);

        // Test 1: unsigned 1000/7 with 16-cycle latency
        in_valid  = 1'b1;
        in_signed = 1'b0;
        dividend  = 16'd1000;
        divisor   = 8'd7;
        in_tag    = 4'h3;
        @(negedge clock);
        in_valid = 1'b0;
        repeat (15) @(negedge clock);
        check("t1_lat_early", 32'(out_valid), 0);
        @(negedge clock);
        check("t1_lat_valid", 32'(out_valid), 1);
        check("t1_q",   32'(quotient), 142);
        check("t1_r",   32'(remainder), 6);
        check("t1_flg", 32'({div_by_zero, overflow}), 0);
        check("t1_tag", 32'(out_tag), 3);
        @(negedge clock);

        // Tests 2-4: directed values and flag cases
        run_op("t2_ffff_ff", 1'b0, 16'hFFFF, 8'hFF, 16'h0101, 8'h00, 1'b0, 1'b0);
        run_op("t2_zero_5",  1'b0, 16'h0000, 8'h05, 16'h0000, 8'h00, 1'b0, 1'b0);
        run_op("t3_m100_7",  1'b1, 16'hFF9C, 8'h07, 16'hFFF2, 8'hFE, 1'b0, 1'b0);
        run_op("t3_100_m7",  1'b1, 16'h0064, 8'hF9, 16'hFFF2, 8'h02, 1'b0, 1'b0);
        run_op("t3_256_m128", 1'b1, 16'h0100, 8'h80, 16'hFFFE, 8'h00, 1'b0, 1'b0);
        run_op("t4_dbz_u",   1'b0, 16'h04D2, 8'h00, 16'hFFFF, 8'hD2, 1'b1, 1'b0);
        run_op("t4_dbz_s",   1'b1, 16'h04D2, 8'h00, 16'hFFFF, 8'hD2, 1'b1, 1'b0);
        run_op("t4_dbz_neg", 1'b1, 16'hFF9C, 8'h00, 16'hFFFF, 8'h9C, 1'b1, 1'b0);
        run_op("t4_ovf",     1'b1, 16'h8000, 8'hFF, 16'h8000, 8'h00, 1'b0, 1'b1);
        run_op("t4_ovf_uns", 1'b0, 16'h8000, 8'hFF, 16'h0080, 8'h80, 1'b0, 1'b0);

        // Test 5: 40 ops streamed with random backpressure and a forced 5-cycle hold
        sent     = 0;
        got      = 0;
        cyc      = 0;
        acc      = 1'b0;
        hold_chk = 1'b0;
        snap     = '0;
        while (got < 40 && cyc < 2000) begin
            if (hold_chk)
                check("t5_hold", 32'({out_valid, quotient, remainder, div_by_zero, overflow, out_tag}), snap);
            if (acc) in_valid = 1'b0;
            acc = 1'b0;
            if (sent < 40 && !in_valid) begin
                in_valid  = 1'b1;
                in_signed = 1'($urandom_range(0, 1));
                dividend  = 16'($urandom);
                divisor   = 8'($urandom);
                in_tag    = 4'(sent);
                if (sent == 7)  divisor = 8'h00;
                if (sent == 20) divisor = 8'h01;
                if (sent == 13) begin
                    in_signed = 1'b1;
                    dividend  = 16'h8000;
                    divisor   = 8'hFF;
                end
            end
            out_ready = (cyc >= 25 && cyc < 30) ? 1'b0 : ($urandom_range(0, 3) != 0);
            #1;
            check("t5_in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
            hold_chk = out_valid && !out_ready;
            if (hold_chk)
                snap = 32'({out_valid, quotient, remainder, div_by_zero, overflow, out_tag});
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    check("t5_unexpected", 32'(out_tag), 32'hFFFF_FFFF);
                end else begin
                    e = expq.pop_front();
                    check("t5_result", 32'({quotient, remainder, div_by_zero, overflow, out_tag}),
                          32'({e.q, e.r, e.dz, e.ov, e.tag}));
                end
                got++;
            end
            if (in_valid && in_ready) begin
                expq.push_back(model(in_signed, dividend, divisor, in_tag));
                sent++;
                acc = 1'b1;
            end
            @(negedge clock);
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("t5_count", 32'(got), 40);
        check("t5_leftover", 32'(expq.size()), 0);
        repeat (2) @(negedge clock);

        // Test 6a: reset with 8 ops in flight discards them all
        for (int i = 0; i < 8; i++) begin
            in_valid  = 1'b1;
            in_signed = 1'b0;
            dividend  = 16'(100 * (i + 1));
            divisor   = 8'd3;
            in_tag    = 4'(i);
            @(negedge clock);
        end
        in_valid = 1'b0;
        repeat (8) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("t6_rst_out_valid", 32'(out_valid), 0);
        reset = 1'b0;
        #1;
        check("t6_rst_in_ready", 32'(in_ready), 1);
        stale = 0;
        repeat (30) begin
            @(negedge clock);
            if (out_valid) stale++;
        end
        check("t6_no_stale", 32'(stale), 0);

        // Test 6b: 4 bits per stage gives a 4-cycle latency with identical values
        in_valid4 = 1'b1;
        in_signed = 1'b0;
        dividend  = 16'd1000;
        divisor   = 8'd7;
        in_tag    = 4'h5;
        @(negedge clock);
        in_valid4 = 1'b0;
        repeat (3) @(negedge clock);
        check("t6_r4_lat_early", 32'(out_valid4), 0);
        @(negedge clock);
        check("t6_r4_lat_valid", 32'(out_valid4), 1);
        check("t6_r4_q",   32'(quotient4), 142);
        check("t6_r4_r",   32'(remainder4), 6);
        check("t6_r4_flg", 32'({div_by_zero4, overflow4}), 0);
        check("t6_r4_tag", 32'(out_tag4), 5);
        @(negedge clock);

        in_valid4 = 1'b1;
        in_signed = 1'b1;
        dividend  = 16'hFF9C;
        divisor   = 8'h07;
        in_tag    = 4'h9;
        @(negedge clock);
        in_valid4 = 1'b0;
        n = 0;
        while (!out_valid4 && n < 20) begin
            @(negedge clock);
            n++;
        end
        check("t6_r4_sgn_valid", 32'(out_valid4), 1);
        check("t6_r4_sgn_qr", 32'({quotient4, remainder4}), 32'({16'hFFF2, 8'hFE}));
        @(negedge clock);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
